// File: rtl/dual_input_debouncer_pkg.sv
// Shared constants for the dual-input debouncer.
//   DB_CNT_MAX_DEFAULT     : hold time in cycles (10 ms at 100 MHz)
//   DB_SYNC_STAGES_DEFAULT : synchroniser depth
//   DB_CNT_MAX_SIM         : short hold time used by simulation benches
package dual_input_debouncer_pkg;

    localparam int DB_CNT_MAX_DEFAULT     = 1000000;
    localparam int DB_SYNC_STAGES_DEFAULT = 2;
    localparam int DB_CNT_MAX_SIM         = 4;

endpackage

// File: rtl/dual_input_debouncer_debounce_channel.sv
// One debounce channel: synchroniser chain followed by a hold counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw asynchronous input
//   db         : debounced level (registered)
//   rise, fall : one-cycle pulses on db transitions (registered)
//   settled    : synchronised input currently equals db (combinational,
//                registered by the parent before leaving the block)
module debounce_channel
    import dual_input_debouncer_pkg::*;
#(
    parameter int CNT_MAX     = DB_CNT_MAX_DEFAULT,
    parameter int SYNC_STAGES = DB_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic settled
);

    localparam int               CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s       = sync[SYNC_STAGES-1];
    assign settled = (s == db);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Counter only runs while s disagrees with db; any return of s to db
    // clears it, so a glitch shorter than CNT_MAX cycles leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                db   <= s;
                rise <= s;
                fall <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dual_input_debouncer.sv
// Two-channel switch/button conditioning front end.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   sw1_raw, sw2_raw     : raw asynchronous inputs
//   in1_db, in2_db       : debounced levels
//   in1_rise/in1_fall    : one-cycle edge pulses for channel 1
//   in2_rise/in2_fall    : one-cycle edge pulses for channel 2
//   stable               : registered "both channels settled" flag
module dual_input_debouncer
    import dual_input_debouncer_pkg::*;
#(
    parameter int CNT_MAX     = DB_CNT_MAX_DEFAULT,
    parameter int SYNC_STAGES = DB_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw1_raw,
    input  logic sw2_raw,
    output logic in1_db,
    output logic in2_db,
    output logic in1_rise,
    output logic in1_fall,
    output logic in2_rise,
    output logic in2_fall,
    output logic stable
);

    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] settled;

    assign raw = {sw2_raw, sw1_raw};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (raw[ch]),
            .db      (db[ch]),
            .rise    (rise[ch]),
            .fall    (fall[ch]),
            .settled (settled[ch])
        );
    end

    assign in1_db   = db[0];
    assign in2_db   = db[1];
    assign in1_rise = rise[0];
    assign in1_fall = fall[0];
    assign in2_rise = rise[1];
    assign in2_fall = fall[1];

    // Registered so no output depends combinationally on the sync chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
        end else begin
            stable <= &settled;
        end
    end

endmodule

// File: tb/tb_dual_input_debouncer.sv
module tb_dual_input_debouncer;
    import dual_input_debouncer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw1_raw = 1'b1;
    logic sw2_raw = 1'b1;
    logic in1_db, in2_db, in1_rise, in1_fall, in2_rise, in2_fall, stable;
    logic [6:0] outs;

    // outs = {in1_db, in2_db, in1_rise, in1_fall, in2_rise, in2_fall, stable}
    assign outs = {in1_db, in2_db, in1_rise, in1_fall, in2_rise, in2_fall, stable};

    dual_input_debouncer #(
        .CNT_MAX     (DB_CNT_MAX_SIM),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw1_raw  (sw1_raw),
        .sw2_raw  (sw2_raw),
        .in1_db   (in1_db),
        .in2_db   (in2_db),
        .in1_rise (in1_rise),
        .in1_fall (in1_fall),
        .in2_rise (in2_rise),
        .in2_fall (in2_fall),
        .stable   (stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sw1;
        logic       sw2;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        logic [6:0] exp;
        logic [6:0] mask;
        string      name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vt[22];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic check(input string name, input logic [6:0] act,
                         input logic [6:0] exp, input logic [6:0] mask);
        chk_cnt++;
        if ((act & mask) == (exp & mask)) pass_cnt++;
        else $display("FAIL %s: got %b expected %b (mask %b)", name, act, exp, mask);
    endtask

    // Called just after a rising edge: drive on the falling edge, push the
    // expectation, then compare 1 time unit after the next rising edge.
    task automatic step(input logic s1, input logic s2, input logic [6:0] exp,
                        input logic [6:0] mask, input string name);
        sb_t e;
        @(negedge clk);
        sw1_raw = s1;
        sw2_raw = s2;
        e.exp  = exp;
        e.mask = mask;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(e.name, outs, e.exp, e.mask);
        end
    endtask

    initial begin
        logic [6:0] e;

        // reset release with raws high (rows 0-7), release of sw1 (8-14),
        // 3-cycle glitch on sw1 with in1_db = 0 (15-21)
        vt[0]  = '{1'b1, 1'b1, 7'b0000001};
        vt[1]  = '{1'b1, 1'b1, 7'b0000001};
        vt[2]  = '{1'b1, 1'b1, 7'b0000000};
        vt[3]  = '{1'b1, 1'b1, 7'b0000000};
        vt[4]  = '{1'b1, 1'b1, 7'b0000000};
        vt[5]  = '{1'b1, 1'b1, 7'b1110100};
        vt[6]  = '{1'b1, 1'b1, 7'b1100001};
        vt[7]  = '{1'b1, 1'b1, 7'b1100001};
        vt[8]  = '{1'b0, 1'b1, 7'b1100001};
        vt[9]  = '{1'b0, 1'b1, 7'b1100001};
        vt[10] = '{1'b0, 1'b1, 7'b1100000};
        vt[11] = '{1'b0, 1'b1, 7'b1100000};
        vt[12] = '{1'b0, 1'b1, 7'b1100000};
        vt[13] = '{1'b0, 1'b1, 7'b0101000};
        vt[14] = '{1'b0, 1'b1, 7'b0100001};
        vt[15] = '{1'b1, 1'b1, 7'b0100001};
        vt[16] = '{1'b1, 1'b1, 7'b0100001};
        vt[17] = '{1'b1, 1'b1, 7'b0100000};
        vt[18] = '{1'b0, 1'b1, 7'b0100000};
        vt[19] = '{1'b0, 1'b1, 7'b0100000};
        vt[20] = '{1'b0, 1'b1, 7'b0100001};
        vt[21] = '{1'b0, 1'b1, 7'b0100001};

        // Reset held with raws high: everything stays at 0.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs, 7'b0000000, 7'b1111111);

        // Release just after an edge so the next edge is edge 1.
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++)
            step(vt[i].sw1, vt[i].sw2, vt[i].exp, 7'b1111111, $sformatf("table[%0d]", i));

        // Independence: sw1 0->1 and sw2 1->0 together.
        for (int k = 1; k <= 7; k++) begin
            if (k <= 2)      e = 7'b0100001;
            else if (k <= 5) e = 7'b0100000;
            else if (k == 6) e = 7'b1010010;
            else             e = 7'b1000001;
            step(1'b1, 1'b0, e, 7'b1111111, $sformatf("indep[%0d]", k));
        end

        // Bounce on sw2: toggle every 2 cycles for 20 cycles, final
        // transition at cycle 19, then hold high -> single rise at 24.
        for (int k = 1; k <= 28; k++) begin
            logic v;
            v = (k > 20) ? 1'b1 : (((k - 1) / 2) % 2 == 1);
            e = {1'b1, (k >= 24), 1'b0, 1'b0, (k == 24), 1'b0, (k >= 25)};
            step(1'b1, v, e, (k >= 25) ? 7'b1111111 : 7'b1111110,
                 $sformatf("bounce[%0d]", k));
        end

        // Reset mid-count: prepare in2_db = 1, in1_db = 0.
        rst_n   = 1'b0;
        sw1_raw = 1'b0;
        sw2_raw = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_prep", outs, 7'b0100001, 7'b1111111);
        step(1'b1, 1'b1, 7'b0100001, 7'b1111111, "midrst_cnt[1]");
        step(1'b1, 1'b1, 7'b0100001, 7'b1111111, "midrst_cnt[2]");
        step(1'b1, 1'b1, 7'b0100000, 7'b1111111, "midrst_cnt[3]");
        rst_n = 1'b0;
        #1;
        check("midrst_async", outs, 7'b0000000, 7'b1111111);
        sw1_raw = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_held", outs, 7'b0000000, 7'b1111111);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 2)      e = 7'b0000001;
            else if (k <= 5) e = 7'b0000000;
            else if (k == 6) e = 7'b0100100;
            else             e = 7'b0100001;
            step(1'b0, 1'b1, e, 7'b1111111, $sformatf("midrst_after[%0d]", k));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
